// File: rtl/sha256_round_engine.sv
// SHA-256 compression round engine: loads H0..H7, runs 64 rounds (one per accepted
// message word) and pulses done when the final working variables are on abcdefgh_out.
module sha256_round_engine (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] h_in,
  input  logic [31:0]  w_in,
  input  logic         w_valid,
  output logic         w_ready,
  output logic         busy,
  output logic         done,
  output logic [255:0] abcdefgh_out,
  output logic [5:0]   round_idx
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] a, b, c, d, e, f, g, h;
  logic [5:0]  t;

  logic [31:0] k;
  logic [31:0] sum0, sum1, ch, maj;
  logic [31:0] t1, t2;
  logic        handshake;

  // Round constants: first 32 bits of the fractional parts of the cube roots of the first 64 primes.
  always_comb begin
    k = 32'h0;
    case (t)
      6'd0:  k = 32'h428a2f98;
      6'd1:  k = 32'h71374491;
      6'd2:  k = 32'hb5c0fbcf;
      6'd3:  k = 32'he9b5dba5;
      6'd4:  k = 32'h3956c25b;
      6'd5:  k = 32'h59f111f1;
      6'd6:  k = 32'h923f82a4;
      6'd7:  k = 32'hab1c5ed5;
      6'd8:  k = 32'hd807aa98;
      6'd9:  k = 32'h12835b01;
      6'd10: k = 32'h243185be;
      6'd11: k = 32'h550c7dc3;
      6'd12: k = 32'h72be5d74;
      6'd13: k = 32'h80deb1fe;
      6'd14: k = 32'h9bdc06a7;
      6'd15: k = 32'hc19bf174;
      6'd16: k = 32'he49b69c1;
      6'd17: k = 32'hefbe4786;
      6'd18: k = 32'h0fc19dc6;
      6'd19: k = 32'h240ca1cc;
      6'd20: k = 32'h2de92c6f;
      6'd21: k = 32'h4a7484aa;
      6'd22: k = 32'h5cb0a9dc;
      6'd23: k = 32'h76f988da;
      6'd24: k = 32'h983e5152;
      6'd25: k = 32'ha831c66d;
      6'd26: k = 32'hb00327c8;
      6'd27: k = 32'hbf597fc7;
      6'd28: k = 32'hc6e00bf3;
      6'd29: k = 32'hd5a79147;
      6'd30: k = 32'h06ca6351;
      6'd31: k = 32'h14292967;
      6'd32: k = 32'h27b70a85;
      6'd33: k = 32'h2e1b2138;
      6'd34: k = 32'h4d2c6dfc;
      6'd35: k = 32'h53380d13;
      6'd36: k = 32'h650a7354;
      6'd37: k = 32'h766a0abb;
      6'd38: k = 32'h81c2c92e;
      6'd39: k = 32'h92722c85;
      6'd40: k = 32'ha2bfe8a1;
      6'd41: k = 32'ha81a664b;
      6'd42: k = 32'hc24b8b70;
      6'd43: k = 32'hc76c51a3;
      6'd44: k = 32'hd192e819;
      6'd45: k = 32'hd6990624;
      6'd46: k = 32'hf40e3585;
      6'd47: k = 32'h106aa070;
      6'd48: k = 32'h19a4c116;
      6'd49: k = 32'h1e376c08;
      6'd50: k = 32'h2748774c;
      6'd51: k = 32'h34b0bcb5;
      6'd52: k = 32'h391c0cb3;
      6'd53: k = 32'h4ed8aa4a;
      6'd54: k = 32'h5b9cca4f;
      6'd55: k = 32'h682e6ff3;
      6'd56: k = 32'h748f82ee;
      6'd57: k = 32'h78a5636f;
      6'd58: k = 32'h84c87814;
      6'd59: k = 32'h8cc70208;
      6'd60: k = 32'h90befffa;
      6'd61: k = 32'ha4506ceb;
      6'd62: k = 32'hbef9a3f7;
      6'd63: k = 32'hc67178f2;
      default: k = 32'h0;
    endcase
  end

  always_comb begin
    sum0 = {a[1:0], a[31:2]} ^ {a[12:0], a[31:13]} ^ {a[21:0], a[31:22]};
    sum1 = {e[5:0], e[31:6]} ^ {e[10:0], e[31:11]} ^ {e[24:0], e[31:25]};
    ch   = (e & f) ^ (~e & g);
    maj  = (a & b) ^ (a & c) ^ (b & c);
    t1   = h + sum1 + ch + k + w_in;
    t2   = sum0 + maj;
  end

  assign w_ready      = (state == ROUND);
  assign handshake    = w_valid & w_ready;
  assign abcdefgh_out = {a, b, c, d, e, f, g, h};
  assign round_idx    = t;

  // t wraps to 0 naturally on the final handshake, ready for the next block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      t     <= 6'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
      a     <= 32'h0;
      b     <= 32'h0;
      c     <= 32'h0;
      d     <= 32'h0;
      e     <= 32'h0;
      f     <= 32'h0;
      g     <= 32'h0;
      h     <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            {a, b, c, d, e, f, g, h} <= h_in;
            t     <= 6'd0;
            busy  <= 1'b1;
            state <= ROUND;
          end
        end
        ROUND: begin
          if (handshake) begin
            h <= g;
            g <= f;
            f <= e;
            e <= d + t1;
            d <= c;
            c <= b;
            b <= a;
            a <= t1 + t2;
            t <= t + 6'd1;
            if (t == 6'd63) begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_round_engine.sv
// Self-checking bench for sha256_round_engine: "abc" block runs with stalls, mid-block
// reset, ignored starts and back-to-back blocks, checked against a scoreboard model.
module tb_sha256_round_engine;

  localparam logic [255:0] H_INIT =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [255:0] h_in;
  logic [31:0]  w_in;
  logic         w_valid;
  logic         w_ready;
  logic         busy;
  logic         done;
  logic [255:0] abcdefgh_out;
  logic [5:0]   round_idx;

  int testsRun = 0;
  int testsFailed = 0;
  logic [255:0] expQ[$];
  logic [31:0]  abcW [64];

  sha256_round_engine dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .h_in         (h_in),
    .w_in         (w_in),
    .w_valid      (w_valid),
    .w_ready      (w_ready),
    .busy         (busy),
    .done         (done),
    .abcdefgh_out (abcdefgh_out),
    .round_idx    (round_idx)
  );

  always #5 clk = ~clk;

  // Safety net in case something upstream hangs.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    logic [63:0] dbl;
    dbl = {x, x} >> n;
    return dbl[31:0];
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Reference compression of the "abc" schedule starting from hv.
  function automatic logic [255:0] modelBlock(input logic [255:0] hv);
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    for (int i = 0; i < 8; i++) v[i] = hv[255 - 32*i -: 32];
    for (int r = 0; r < 64; r++) begin
      t1 = v[7] + bsig1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K_TAB[r] + abcW[r];
      t2 = bsig0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    return {v[0], v[1], v[2], v[3], v[4], v[5], v[6], v[7]};
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Runs one "abc" block starting in an IDLE cycle (called at a negedge) and ends
  // at the negedge of the following IDLE cycle.
  task automatic applyStimulus(input string tag, input bit randomStall, input int startPulseAt,
                               input bit startInDone, input int resetAt);
    int hs;
    int edges;
    bit aborted;
    bit sawDone;
    logic [255:0] expv;

    h_in    = H_INIT;
    start   = 1'b1;
    w_valid = 1'($urandom_range(0, 1));
    w_in    = 32'hffffffff;
    expv    = '0;
    if (resetAt < 0) expQ.push_back(modelBlock(H_INIT));
    @(negedge clk);
    start = 1'b0;
    edges = 1;
    checkOutput({tag, "_load"}, abcdefgh_out, H_INIT);
    checkOutput({tag, "_busy_round"}, 256'(busy), 256'(1));
    checkOutput({tag, "_wready_round"}, 256'(w_ready), 256'(1));

    hs = 0;
    aborted = 1'b0;
    for (int cyc = 0; cyc < 2000 && hs < 64; cyc++) begin
      checkOutput({tag, "_idx"}, 256'(round_idx), 256'(hs));
      if (hs == resetAt) begin
        rst = 1'b1;
        #1;
        checkOutput({tag, "_rst_out"}, abcdefgh_out, 256'(0));
        checkOutput({tag, "_rst_flags"}, 256'({busy, done, w_ready}), 256'(0));
        checkOutput({tag, "_rst_idx"}, 256'(round_idx), 256'(0));
        @(negedge clk);
        rst = 1'b0;
        w_valid = 1'b1;
        sawDone = 1'b0;
        repeat (70) begin
          @(negedge clk);
          sawDone |= done;
        end
        checkOutput({tag, "_no_done_after_abort"}, 256'({sawDone, busy}), 256'(0));
        checkOutput({tag, "_idle_hold"}, abcdefgh_out, 256'(0));
        aborted = 1'b1;
        break;
      end
      w_valid = randomStall ? 1'($urandom_range(0, 1)) : 1'b1;
      w_in = abcW[hs];
      if (hs == startPulseAt) begin
        start = 1'b1;
        h_in  = ~H_INIT;
      end
      @(negedge clk);
      edges++;
      start = 1'b0;
      h_in  = H_INIT;
      if (w_valid) begin
        hs++;
        if (hs == 1) begin
          checkOutput({tag, "_r0_a"}, 256'(abcdefgh_out[255:224]), 256'(32'h5d6aebcd));
          checkOutput({tag, "_r0_e"}, 256'(abcdefgh_out[127:96]), 256'(32'hfa2a4622));
        end
      end
    end

    if (!aborted) begin
      checkOutput({tag, "_handshakes"}, 256'(hs), 256'(64));
      checkOutput({tag, "_done"}, 256'(done), 256'(1));
      checkOutput({tag, "_busy_done"}, 256'(busy), 256'(1));
      checkOutput({tag, "_wready_done"}, 256'(w_ready), 256'(0));
      checkOutput({tag, "_idx_wrap"}, 256'(round_idx), 256'(0));
      // Counting the start-sampling edge as edge 1: 1 load + 64 rounds.
      if (!randomStall) checkOutput({tag, "_latency"}, 256'(edges), 256'(65));
      checkOutput({tag, "_sb_size"}, 256'(expQ.size()), 256'(1));
      if (expQ.size() != 0) expv = expQ.pop_front();
      checkOutput({tag, "_result"}, abcdefgh_out, expv);
      checkOutput({tag, "_a_final"}, 256'(abcdefgh_out[255:224]), 256'(32'h506e3058));
      checkOutput({tag, "_digest0"}, 256'(abcdefgh_out[255:224] + 32'h6a09e667), 256'(32'hba7816bf));

      w_valid = 1'b1;
      if (startInDone) begin
        start = 1'b1;
        h_in  = ~H_INIT;
      end
      @(negedge clk);
      start = 1'b0;
      h_in  = H_INIT;
      checkOutput({tag, "_idle_flags"}, 256'({busy, done, w_ready}), 256'(0));
      checkOutput({tag, "_idle_out"}, abcdefgh_out, expv);
      checkOutput({tag, "_idle_idx"}, 256'(round_idx), 256'(0));
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) abcW[i] = 32'h0;
    abcW[0]  = 32'h61626380;
    abcW[15] = 32'h00000018;
    for (int i = 16; i < 64; i++)
      abcW[i] = ssig1(abcW[i-2]) + abcW[i-7] + ssig0(abcW[i-15]) + abcW[i-16];

    rst     = 1'b1;
    start   = 1'b0;
    w_valid = 1'b0;
    w_in    = 32'h0;
    h_in    = 256'h0;
    @(negedge clk);
    checkOutput("reset_out", abcdefgh_out, 256'(0));
    checkOutput("reset_flags", 256'({busy, done, w_ready}), 256'(0));
    checkOutput("reset_idx", 256'(round_idx), 256'(0));
    rst = 1'b0;
    w_valid = 1'b1;
    @(negedge clk);
    checkOutput("idle_ignores_wvalid", abcdefgh_out, 256'(0));

    applyStimulus("abc", 1'b0, -1, 1'b0, -1);
    applyStimulus("stall", 1'b1, -1, 1'b0, -1);
    applyStimulus("reset_mid", 1'b0, -1, 1'b0, 30);
    applyStimulus("after_reset", 1'b0, -1, 1'b0, -1);
    applyStimulus("ignored_start", 1'b1, 10, 1'b1, -1);
    applyStimulus("back_to_back", 1'b0, -1, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/sha256_round_engine.md
SHA256_ROUND_ENGINE -- requirements
Module: sha256_round_engine

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  asynchronous active-high reset.
REQ-004 Port: start  input  1  begin a block; sampled only in IDLE.
REQ-005 Port: h_in  input  256  chaining value H0..H7; H0 = h_in[255:224], H7 = h_in[31:0].
REQ-006 Port: w_in  input  32  message-schedule word W_t.
REQ-007 Port: w_valid  input  1  W_t present on w_in.
REQ-008 Port: w_ready  output  1  engine accepts W_t this cycle.
REQ-009 Port: busy  output  1  high in ROUND and DONE.
REQ-010 Port: done  output  1  one-cycle pulse when the final working variables are valid.
REQ-011 Port: abcdefgh_out  output  256  working variables {a,b,c,d,e,f,g,h}, with a in [255:224]; feeds the per-word H adders.
REQ-012 Port: round_idx  output  6  index t of the next round to execute.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, ROUND and DONE.
REQ-014 IDLE: when start=1, load a..h from h_in, set t=0 and go to ROUND next cycle; when start=0, hold all registers.
REQ-015 ROUND: w_ready=1 combinationally; a handshake (w_valid & w_ready) executes exactly one SHA-256 round with W_t=w_in and K_t from an internal 64-entry FIPS 180-4 constant table.
REQ-016 Round update, all arithmetic mod 2^32:
- T1 = h + Σ1(e) + Ch(e,f,g) + K_t + W_t
- T2 = Σ0(a) + Maj(a,b,c)
- h←g, g←f, f←e, e←d+T1, d←c, c←b, b←a, a←T1+T2
REQ-017 Σ0 = ROTR2^ROTR13^ROTR22; Σ1 = ROTR6^ROTR11^ROTR25; Ch = (e&f)^(~e&g); Maj = (a&b)^(a&c)^(b&c).
REQ-018 ROUND with w_valid=0: stall; a..h and t unchanged; no timeout.
REQ-019 t SHALL increment by 1 on each handshake; the handshake at t=63 SHALL move the FSM to DONE, and t SHALL wrap to 0.
REQ-020 DONE: done=1, w_ready=0, abcdefgh_out holds the final values for exactly one cycle; the FSM returns to IDLE on the next cycle unconditionally.
REQ-021 abcdefgh_out SHALL be driven directly from the a..h registers in all states; it holds its value through IDLE until the next start.
REQ-022 start asserted in ROUND or DONE SHALL be ignored, with no reload and no effect on t.
REQ-023 w_ready SHALL be 0 in IDLE and DONE; w_valid in those states SHALL be ignored.
REQ-024 Latency: with w_valid held at 1, done rises exactly 65 cycles after the start-sampling edge (1 load, 64 rounds).
REQ-025 A start sampled in the IDLE cycle immediately following DONE SHALL be accepted, giving back-to-back blocks with one idle cycle between them.

Reset
REQ-026 Asserting rst SHALL immediately force: state=IDLE, t=0, a..h=0, abcdefgh_out=0, done=0, busy=0, w_ready=0.
REQ-027 Reset mid-ROUND SHALL abandon the block; after rst deasserts, the engine waits for a new start and no done is issued for the abandoned block.
REQ-028 rst deassertion SHALL be synchronised externally; the block adds no synchronizer.

Verification
REQ-029 "abc" round 0: h_in = FIPS initial H (6a09e667…5be0cd19), W_0=0x61626380, start -> after the first handshake a=0x5d6aebcd, e=0xfa2a4622.
REQ-030 "abc" full block: 64 padded-schedule words with w_valid=1 -> done at cycle 65, abcdefgh_out[255:224]=0x506e3058; adding 0x6a09e667 yields 0xba7816bf.
REQ-031 Stall: repeat the "abc" run with w_valid toggled by a random pattern -> identical final abcdefgh_out, done one cycle after the 64th handshake, round_idx never skips.
REQ-032 Reset mid-operation: assert rst at t=30 -> all outputs 0 immediately; a fresh "abc" run afterwards matches REQ-030.
REQ-033 Ignored start: pulse start at t=10 and in the DONE cycle -> no reload and the result is unchanged; start in the following IDLE cycle launches a second block correctly.
